wb_ram_loader: RTL and testbench

- Wishbone slave that gives the management core load/dump access to the four 1K x 16 program/data RAM banks (4K words total).
- Sits directly upstream of the SoC config/mux stage, producing the loader-side address, data, enable and rw bundle that the mux selects in place of the CPU bundle.
- Also consumes the bank-muxed read data coming back out of that mux.
- Provides a hold control bit that stalls the CPU and hands RAM ownership to the loader.

---
 rtl/wb_ram_loader.sv | 174 +++++++++++++++++
 tb/tb_wb_ram_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_loader.sv
// rtl/wb_ram_loader.sv - Wishbone loader giving the management core load/dump access to the program/data RAM banks
module wb_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] data_from_mem,
  output logic        ld_active_o,
  output logic        cpu_hold_o,
  output logic        ld_en_o,
  output logic        ld_rw_o,
  output logic [11:0] ld_addr_o,
  output logic [15:0] ld_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_hold;
  logic [15:0] r_wcount;
  logic        r_we;
  logic        r_sel_ok;
  logic [11:0] r_addr;
  logic [15:0] r_data;
  logic [2:0]  r_cnt;
  logic [31:0] r_dat_o;
  logic        r_reg_wr;
  logic        r_reg_idx;
  logic        r_reg_bit0;

  logic        w_hit;
  logic        w_is_reg;
  logic        w_en;
  logic        w_ack;
  logic        w_unused;

  assign w_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:15] == BASE_ADDR[31:15]);
  assign w_is_reg = wbs_adr_i[14];
  assign w_unused = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An abort drops back to IDLE from ACCESS or WAIT without ever reaching ACK.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_next = (!w_is_reg && r_hold) ? S_ACCESS : S_ACK;
        end
      end
      S_ACCESS: begin
        if (!wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (r_we) begin
          w_next = S_ACK;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == 3'd0) begin
          w_next = S_ACK;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_en  = 1'b0;
    w_ack = 1'b0;
    case (r_state)
      S_ACCESS: w_en  = !r_we || r_sel_ok;
      S_ACK:    w_ack = 1'b1;
      default: ;
    endcase
  end

  // Register writes land on the ACK edge, so hold changes are seen only after the ack.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_hold     <= 1'b0;
      r_wcount   <= 16'd0;
      r_we       <= 1'b0;
      r_sel_ok   <= 1'b0;
      r_addr     <= 12'd0;
      r_data     <= 16'd0;
      r_cnt      <= 3'd0;
      r_dat_o    <= 32'd0;
      r_reg_wr   <= 1'b0;
      r_reg_idx  <= 1'b0;
      r_reg_bit0 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_reg_wr <= 1'b0;
            if (w_is_reg) begin
              r_reg_wr   <= wbs_we_i;
              r_reg_idx  <= wbs_adr_i[2];
              r_reg_bit0 <= wbs_dat_i[0];
              if (!wbs_we_i) begin
                r_dat_o <= wbs_adr_i[2] ? {16'd0, r_wcount} : {31'd0, r_hold};
              end
            end else if (r_hold) begin
              r_addr   <= wbs_adr_i[13:2];
              r_data   <= wbs_dat_i[15:0];
              r_we     <= wbs_we_i;
              r_sel_ok <= |wbs_sel_i[1:0];
            end else begin
              r_dat_o <= 32'd0;
            end
          end
        end
        S_ACCESS: begin
          if (w_en && r_we) begin
            r_wcount <= r_wcount + 16'd1;
          end
          if (!r_we) begin
            r_cnt <= 3'(READ_LAT - 1);
          end
        end
        S_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else if (wbs_cyc_i) begin
            r_dat_o <= {16'd0, data_from_mem};
          end
        end
        S_ACK: begin
          if (r_reg_wr) begin
            if (r_reg_idx) begin
              r_wcount <= 16'd0;
            end else begin
              r_hold <= r_reg_bit0;
            end
            r_reg_wr <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wbs_ack_o   = w_ack;
  assign wbs_dat_o   = r_dat_o;
  assign ld_en_o     = w_en;
  assign ld_rw_o     = r_we;
  assign ld_addr_o   = r_addr;
  assign ld_data_o   = r_data;
  assign ld_active_o = r_hold;
  assign cpu_hold_o  = r_hold;

endmodule

// File: tb/tb_wb_ram_loader.sv
// tb/tb_wb_ram_loader.sv - scoreboard bench for wb_ram_loader
module tb_wb_ram_loader;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam int          READ_LAT = 2;

  logic        clk;
  logic        wb_rst_ni;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] data_from_mem;
  logic        ld_active_o;
  logic        cpu_hold_o;
  logic        ld_en_o;
  logic        ld_rw_o;
  logic [11:0] ld_addr_o;
  logic [15:0] ld_data_o;

  wb_ram_loader #(.BASE_ADDR(BASE), .READ_LAT(READ_LAT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .data_from_mem(data_from_mem),
    .ld_active_o(ld_active_o), .cpu_hold_o(cpu_hold_o), .ld_en_o(ld_en_o), .ld_rw_o(ld_rw_o),
    .ld_addr_o(ld_addr_o), .ld_data_o(ld_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk_data;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  typedef struct {
    bit          rw;
    logic [11:0] addr;
    logic [15:0] data;
  } ldop_t;

  exp_t        ack_q[$];
  ldop_t       ld_q[$];
  logic [15:0] ref_mem [4096];
  logic [15:0] ram [4096];
  bit          ref_hold;
  logic [15:0] ref_wcount;
  int          n_checks;
  int          n_fail;
  time         issue_t;
  int          rd_k;
  logic [11:0] rd_addr;
  exp_t        m_e;
  ldop_t       m_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM behind the mux: data is valid only in the cycle the loader samples it.
  always @(negedge clk) begin
    if (rd_k > 0) begin
      rd_k--;
      data_from_mem = (rd_k == 0) ? ram[rd_addr] : 16'($urandom);
    end else begin
      data_from_mem = 16'($urandom);
    end
    if (ld_en_o && !ld_rw_o) begin
      rd_k    = READ_LAT;
      rd_addr = ld_addr_o;
    end
    if (ld_en_o && ld_rw_o) ram[ld_addr_o] = ld_data_o;
  end

  always @(negedge clk) begin
    if (wb_rst_ni) begin
      if (wbs_ack_o) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          m_e = ack_q.pop_front();
          chk("ack_latency", 32'(int'(($time - issue_t) / 10) + 1), 32'(m_e.lat));
          if (m_e.chk_data) chk("read_data", wbs_dat_o, m_e.dat);
        end
      end
      if (ld_en_o) begin
        if (ld_q.size() == 0) begin
          chk("unexpected_ld_en", 32'd1, 32'd0);
        end else begin
          m_op = ld_q.pop_front();
          chk("ld_rw", 32'(ld_rw_o), 32'(m_op.rw));
          chk("ld_addr", 32'(ld_addr_o), 32'(m_op.addr));
          if (m_op.rw) chk("ld_data", 32'(ld_data_o), 32'(m_op.data));
        end
      end
    end
  end

  task automatic drive(input logic [31:0] adr, input bit we, input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    issue_t   = $time;
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] dat, input logic [3:0] sel);
    exp_t        e;
    bit          hit;
    bit          ok;
    logic [11:0] w;
    hit        = (adr[31:15] == BASE[31:15]);
    w          = adr[13:2];
    e.chk_data = !we;
    e.dat      = 32'd0;
    e.lat      = 2;
    if (hit) begin
      if (adr[14]) begin
        if (!we) e.dat = adr[2] ? {16'h0, ref_wcount} : {31'h0, ref_hold};
        else if (adr[2]) ref_wcount = 16'd0;
        else ref_hold = dat[0];
      end else if (ref_hold) begin
        if (we) begin
          e.lat = 3;
          if (sel[1:0] != 2'b00) begin
            ld_q.push_back('{1'b1, w, dat[15:0]});
            ref_mem[w] = dat[15:0];
            ref_wcount = ref_wcount + 16'd1;
          end
        end else begin
          e.lat = 3 + READ_LAT;
          e.dat = {16'h0, ref_mem[w]};
          ld_q.push_back('{1'b0, w, dat[15:0]});
        end
      end
      ack_q.push_back(e);
    end
    drive(adr, we, dat, sel);
    if (hit) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (wbs_ack_o) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      repeat (6) @(negedge clk);
    end
    release_bus();
  endtask

  // RAM access with hold set, abandoned by dropping cyc after drop_after cycles.
  task automatic wb_abort(input logic [31:0] adr, input bit we, input logic [31:0] dat, input logic [3:0] sel,
                          input int drop_after);
    logic [11:0] w;
    w = adr[13:2];
    if (!we) begin
      ld_q.push_back('{1'b0, w, dat[15:0]});
    end else if (sel[1:0] != 2'b00) begin
      ld_q.push_back('{1'b1, w, dat[15:0]});
      ref_mem[w] = dat[15:0];
      ref_wcount = ref_wcount + 16'd1;
    end
    drive(adr, we, dat, sel);
    repeat (drop_after) @(negedge clk);
    release_bus();
    repeat (8) @(negedge clk);
  endtask

  task automatic set_hold(input bit v);
    bit old;
    old = ref_hold;
    wb_xfer(BASE | 32'h4000, 1'b1, {31'h0, v}, 4'hF);
    chk("hold_during_ack", 32'(cpu_hold_o), 32'(old));
    @(negedge clk);
    chk("cpu_hold_after", 32'(cpu_hold_o), 32'(v));
    chk("ld_active_after", 32'(ld_active_o), 32'(v));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(wbs_ack_o), 32'd0);
    chk({tag, "_dat"}, wbs_dat_o, 32'd0);
    chk({tag, "_en"}, 32'(ld_en_o), 32'd0);
    chk({tag, "_rw"}, 32'(ld_rw_o), 32'd0);
    chk({tag, "_addr"}, 32'(ld_addr_o), 32'd0);
    chk({tag, "_data"}, 32'(ld_data_o), 32'd0);
    chk({tag, "_active"}, 32'(ld_active_o), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    logic [11:0] w;
    int          op;
    n_checks   = 0;
    n_fail     = 0;
    ref_hold   = 1'b0;
    ref_wcount = 16'd0;
    rd_k       = 0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 16'd0;
      ram[i]     = 16'd0;
    end
    wb_rst_ni = 1'b0;
    wbs_adr_i = 32'd0;
    wbs_dat_i = 32'd0;
    wbs_sel_i = 4'd0;
    release_bus();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    wb_rst_ni = 1'b1;

    set_hold(1'b1);
    wb_xfer(BASE | 32'h4000, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0C08, 1'b1, 32'hDEAD_BEEF, 4'h3);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0C08, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0C10, 1'b1, 32'h0000_5555, 4'h0);

    set_hold(1'b0);
    wb_xfer(32'h3000_0010, 1'b1, 32'h0000_1234, 4'h3);
    wb_xfer(32'h3000_0010, 1'b0, 32'd0, 4'hF);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);

    set_hold(1'b1);
    wb_abort(32'h3000_0C08, 1'b0, 32'd0, 4'hF, 2);
    wb_xfer(32'h3100_0000, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0C08, 1'b0, 32'd0, 4'hF);
    wb_abort(32'h3000_2004, 1'b1, 32'h0000_A5A5, 4'h1, 1);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_2004, 1'b0, 32'd0, 4'hF);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 15);
      w  = 12'($urandom_range(0, 63) * 64 + $urandom_range(0, 1));
      adr = BASE | {18'd0, w, 2'($urandom)};
      if (op <= 4) begin
        wb_xfer(adr, 1'b1, $urandom, 4'($urandom));
      end else if (op <= 8) begin
        wb_xfer(adr, 1'b0, $urandom, 4'($urandom));
      end else if (op == 9) begin
        wb_xfer(BASE | 32'h4000 | {18'd0, 11'($urandom), 3'b000}, 1'b1, $urandom_range(0, 3) != 0, 4'hF);
      end else if (op == 10) begin
        wb_xfer(BASE | 32'h4004 | {18'd0, 11'($urandom), 3'b000}, 1'b0, 32'd0, 4'hF);
      end else if (op == 11) begin
        wb_xfer(BASE | 32'h4000, 1'b0, 32'd0, 4'hF);
      end else if (op == 12) begin
        if ($urandom_range(0, 3) == 0) wb_xfer(BASE | 32'h4004, 1'b1, $urandom, 4'hF);
        else wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
      end else if (op == 13) begin
        wb_xfer(BASE ^ (32'd1 << $urandom_range(15, 31)), 1'($urandom), $urandom, 4'hF);
      end else begin
        if (!ref_hold) set_hold(1'b1);
        wb_xfer(adr, 1'b0, 32'd0, 4'hF);
      end
    end

    if (!ref_hold) set_hold(1'b1);
    repeat (2) @(negedge clk);
    force dut.r_wcount = 16'hFFFE;
    @(negedge clk);
    release dut.r_wcount;
    ref_wcount = 16'hFFFE;
    wb_xfer(32'h3000_0100, 1'b1, 32'h0000_0001, 4'h2);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0104, 1'b1, 32'h0000_0002, 4'h1);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
    wb_xfer(32'h3000_0108, 1'b1, 32'h0000_0003, 4'h3);
    wb_xfer(BASE | 32'h4004, 1'b1, 32'hFFFF_FFFF, 4'hF);
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);

    ld_q.push_back('{1'b1, 12'h0AB, 16'h7777});
    ref_mem[12'h0AB] = 16'h7777;
    drive(32'h3000_02AC, 1'b1, 32'h0000_7777, 4'h3);
    @(negedge clk);
    #1;
    wb_rst_ni = 1'b0;
    release_bus();
    @(negedge clk);
    chk_all_zero("rst_access");
    ref_hold   = 1'b0;
    ref_wcount = 16'd0;
    wb_rst_ni  = 1'b1;
    wb_xfer(BASE | 32'h4004, 1'b0, 32'd0, 4'hF);
    wb_xfer(BASE | 32'h4000, 1'b0, 32'd0, 4'hF);
    repeat (4) @(negedge clk);

    chk("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    chk("ld_queue_empty", 32'(ld_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
